// File: rtl/codec_cfg_pkg.sv
// Shared types and the default WM8731 configuration table for the codec
// initialisation sequencer.
package codec_cfg_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWR_WAIT,
      S_LOAD,
      S_START,
      S_SETTLE,
      S_WAIT_DONE,
      S_CHECK,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_t;

   // Table word: {register address[6:0], register value[8:0]}
   typedef logic [15:0] cfg_word_t;

   localparam int unsigned DEFAULT_LEN = 11;

   function automatic cfg_word_t cfg_word(input logic [6:0] addr, input logic [8:0] data);
      return {addr, data};
   endfunction

   // Reset the codec first, then program line-in, headphone, path, power,
   // interface, sampling and finally activate.
   localparam cfg_word_t DEFAULT_TABLE [DEFAULT_LEN] = '{
      cfg_word(7'd15, 9'h000),
      cfg_word(7'd0,  9'h017),
      cfg_word(7'd1,  9'h017),
      cfg_word(7'd2,  9'h079),
      cfg_word(7'd3,  9'h079),
      cfg_word(7'd4,  9'h012),
      cfg_word(7'd5,  9'h000),
      cfg_word(7'd6,  9'h000),
      cfg_word(7'd7,  9'h001),
      cfg_word(7'd8,  9'h000),
      cfg_word(7'd9,  9'h001)
   };

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of a configuration table entry by index.
// Indices outside the table return an all-zero word.
module codec_cfg_rom
   import codec_cfg_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEFAULT_LEN
) (
   input  logic [3:0] index,
   output cfg_word_t  word
);

   // Table lookup with out-of-range guard
   always_comb begin
      word = '0;
      if ((32'(index) < NUM_REGS) && (32'(index) < DEFAULT_LEN)) begin
         word = DEFAULT_TABLE[index];
      end
   end

endmodule

// File: rtl/codec_init_seq.sv
// Codec initialisation sequencer: after a power-up delay, writes every
// configuration table entry through an external I2C controller, retrying
// NACKed entries up to MAX_RETRY attempts in total.
module codec_init_seq
   import codec_cfg_pkg::*;
#(
   parameter logic [7:0]  DEV_ADDR   = 8'h34,
   parameter int unsigned NUM_REGS   = 11,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned PWR_DELAY  = 50000,
   parameter int unsigned GAP_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   output logic        i2c_start,
   output logic [23:0] i2c_data,
   input  logic        i2c_done,
   input  logic        i2c_ack,
   output logic        busy,
   output logic        config_done,
   output logic        config_err,
   output logic [3:0]  reg_index
);

   state_t      state;
   state_t      state_next;
   logic [31:0] cnt;
   logic [31:0] retry;
   logic        ack_q;
   cfg_word_t   rom_word;
   logic        last_entry;
   logic        retry_exhausted;
   logic        pwr_expired;
   logic        gap_expired;

   codec_cfg_rom #(
      .NUM_REGS(NUM_REGS)
   ) u_rom (
      .index(reg_index),
      .word (rom_word)
   );

   assign last_entry      = ({28'd0, reg_index} == (NUM_REGS - 32'd1));
   assign retry_exhausted = ((retry + 32'd1) >= MAX_RETRY);
   // PWR_WAIT spans PWR_DELAY+1 cycles so the first start lands PWR_DELAY+3 cycles after go
   assign pwr_expired     = (cnt >= PWR_DELAY);
   assign gap_expired     = ((cnt + 32'd1) >= GAP_CYCLES);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_next  = state;
      i2c_start   = 1'b0;
      busy        = 1'b1;
      config_done = 1'b0;
      config_err  = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (go) state_next = S_PWR_WAIT;
         end
         S_PWR_WAIT: if (pwr_expired) state_next = S_LOAD;
         S_LOAD:     state_next = S_START;
         S_START: begin
            i2c_start  = 1'b1;
            state_next = S_SETTLE;
         end
         // Ignore i2c_done here: it may still be high from the previous transfer
         S_SETTLE:    state_next = S_WAIT_DONE;
         S_WAIT_DONE: if (i2c_done) state_next = S_CHECK;
         S_CHECK: begin
            if (ack_q) begin
               state_next = last_entry ? S_DONE : S_GAP;
            end else begin
               state_next = retry_exhausted ? S_ERROR : S_GAP;
            end
         end
         S_GAP: if (gap_expired) state_next = S_LOAD;
         S_DONE: begin
            busy        = 1'b0;
            config_done = 1'b1;
            if (go) state_next = S_PWR_WAIT;
         end
         S_ERROR: begin
            busy       = 1'b0;
            config_err = 1'b1;
            if (go) state_next = S_PWR_WAIT;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Counters, table index, retry bookkeeping and the outgoing I2C word
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         retry     <= '0;
         reg_index <= '0;
         ack_q     <= 1'b0;
         i2c_data  <= '0;
      end else begin
         cnt <= '0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (go) begin
                  reg_index <= '0;
                  retry     <= '0;
               end
            end
            S_PWR_WAIT, S_GAP: cnt <= cnt + 32'd1;
            S_LOAD:            i2c_data <= {DEV_ADDR, rom_word};
            // ack is only valid alongside done, so capture it here
            S_WAIT_DONE:       if (i2c_done) ack_q <= i2c_ack;
            S_CHECK: begin
               if (ack_q) begin
                  if (!last_entry) begin
                     reg_index <= reg_index + 4'd1;
                     retry     <= '0;
                  end
               end else begin
                  retry <= retry + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq with a simple I2C controller model that
// raises done 40 cycles after each start and holds it until the next one.
module tb_codec_init_seq;

   localparam int unsigned PWR = 4;
   localparam int unsigned GAP = 2;
   localparam int unsigned XFER = 40;
   // start-to-start: XFER, +1 see done, +1 CHECK, GAP, +1 LOAD, +1 START
   localparam int SPACING = XFER + 4 + GAP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic        i2c_start;
   logic [23:0] i2c_data;
   logic        i2c_done = 1'b0;
   logic        i2c_ack = 1'b0;
   logic        busy;
   logic        config_done;
   logic        config_err;
   logic [3:0]  reg_index;

   int vectors = 0;
   int miscompares = 0;

   // Controller model state
   logic        bfm_clr = 1'b0;
   logic [23:0] nack_always = 24'hFFFFFF;
   logic [23:0] nack_once = 24'hFFFFFF;
   int          bfm_cnt = 0;
   logic        bfm_drop = 1'b0;
   logic        pend_ack = 1'b1;
   int          hits = 0;
   int          cyc = 0;
   int          n_start = 0;
   logic [23:0] log_data[$];
   int          start_cyc[$];

   logic [23:0] exp_data [11] = '{
      24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
      24'h340A00, 24'h340C00, 24'h340E01, 24'h341000, 24'h341201
   };

   codec_init_seq #(
      .PWR_DELAY (PWR),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .go         (go),
      .i2c_start  (i2c_start),
      .i2c_data   (i2c_data),
      .i2c_done   (i2c_done),
      .i2c_ack    (i2c_ack),
      .busy       (busy),
      .config_done(config_done),
      .config_err (config_err),
      .reg_index  (reg_index)
   );

   always #5 clk = ~clk;

   // I2C controller model: done drops one cycle after start, rises XFER cycles after start
   always @(posedge clk) begin
      cyc++;
      if (bfm_clr) begin
         i2c_done <= 1'b0;
         i2c_ack  <= 1'b0;
         bfm_cnt  = 0;
         bfm_drop = 1'b0;
         hits     = 0;
      end else if (i2c_start) begin
         log_data.push_back(i2c_data);
         start_cyc.push_back(cyc);
         n_start++;
         bfm_cnt  = XFER;
         bfm_drop = 1'b1;
         if (i2c_data == nack_always) pend_ack = 1'b0;
         else if (i2c_data == nack_once && hits < 1) begin
            pend_ack = 1'b0;
            hits++;
         end else pend_ack = 1'b1;
      end else begin
         if (bfm_drop) begin
            i2c_done <= 1'b0;
            bfm_drop = 1'b0;
         end
         if (bfm_cnt > 0) begin
            if (bfm_cnt == 1) begin
               i2c_done <= 1'b1;
               i2c_ack  <= pend_ack;
            end
            bfm_cnt--;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_go();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_starts(input int n, input string tag);
      int c = 0;
      while (n_start < n && c < 2000) begin
         tick(1);
         c++;
      end
      chk(tag, 32'(n_start >= n), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while (busy !== 1'b0 && c < 2000) begin
         tick(1);
         c++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int base;
      int e;

      // Reset state
      tick(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(config_done), 0);
      chk("rst_err", 32'(config_err), 0);
      chk("rst_index", 32'(reg_index), 0);
      chk("rst_start", 32'(i2c_start), 0);
      chk("rst_data", 32'(i2c_data), 0);
      @(negedge clk);
      rst = 1'b0;

      // Full pass with latency check and a go while busy
      base = n_start;
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      e = 1;
      chk("pwr_busy", 32'(busy), 1);
      while (!i2c_start && e < 100) begin
         tick(1);
         e++;
      end
      chk("go_to_start", 32'(e), PWR + 3);
      wait_starts(base + 3, "t1_third_start");
      tick(10);
      pulse_go();
      tick(1);
      chk("busy_go_index", 32'(reg_index), 2);
      chk("busy_go_busy", 32'(busy), 1);
      wait_idle("t1_finish");
      chk("t1_starts", 32'(n_start - base), 11);
      chk("t1_first_data", 32'(log_data[base]), 32'h341E00);
      chk("t1_second_data", 32'(log_data[base+1]), 32'h340017);
      for (int i = 2; i < 11; i++) chk($sformatf("t1_data%0d", i), 32'(log_data[base+i]), 32'(exp_data[i]));
      for (int i = 1; i < 11; i++) chk($sformatf("t1_gap%0d", i), 32'(start_cyc[base+i] - start_cyc[base+i-1]), SPACING);
      chk("t1_config_done", 32'(config_done), 1);
      chk("t1_err", 32'(config_err), 0);
      chk("t1_index", 32'(reg_index), 10);

      // Single NACK on entry 3 (R2 = 0x079)
      base = n_start;
      nack_once = 24'h340479;
      pulse_go();
      wait_idle("t2_finish");
      chk("t2_starts", 32'(n_start - base), 12);
      chk("t2_try1", 32'(log_data[base+3]), 32'h340479);
      chk("t2_try2", 32'(log_data[base+4]), 32'h340479);
      chk("t2_next", 32'(log_data[base+5]), 32'h340679);
      chk("t2_last", 32'(log_data[base+11]), 32'h341201);
      chk("t2_retry_gap", 32'(start_cyc[base+4] - start_cyc[base+3]), SPACING);
      chk("t2_config_done", 32'(config_done), 1);

      // Persistent NACK on entry 5
      base = n_start;
      nack_always = 24'h340812;
      pulse_go();
      wait_idle("t3_finish");
      chk("t3_starts", 32'(n_start - base), 8);
      for (int i = 5; i < 8; i++) chk($sformatf("t3_try%0d", i - 4), 32'(log_data[base+i]), 32'h340812);
      chk("t3_err", 32'(config_err), 1);
      chk("t3_done", 32'(config_done), 0);
      chk("t3_index", 32'(reg_index), 5);
      tick(200);
      chk("t3_no_more_start", 32'(n_start - base), 8);

      // go after ERROR reruns from entry 0
      base = n_start;
      nack_always = 24'hFFFFFF;
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      chk("t4_err_clear", 32'(config_err), 0);
      chk("t4_busy", 32'(busy), 1);
      chk("t4_index", 32'(reg_index), 0);
      wait_idle("t4_finish");
      chk("t4_starts", 32'(n_start - base), 11);
      chk("t4_first", 32'(log_data[base]), 32'h341E00);
      chk("t4_config_done", 32'(config_done), 1);

      // Reset during WAIT_DONE of entry 4
      base = n_start;
      pulse_go();
      wait_starts(base + 5, "t5_fifth_start");
      tick(10);
      chk("t5_pre_index", 32'(reg_index), 4);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_start", 32'(i2c_start), 0);
      chk("t5_data", 32'(i2c_data), 0);
      chk("t5_index", 32'(reg_index), 0);
      chk("t5_done_err", 32'({config_done, config_err}), 0);
      @(negedge clk);
      rst = 1'b0;
      tick(60);
      chk("t5_idle_no_start", 32'(n_start - base), 5);
      base = n_start;
      pulse_go();
      wait_idle("t5_finish");
      chk("t5_restart_first", 32'(log_data[base]), 32'h341E00);
      chk("t5_starts", 32'(n_start - base), 11);
      chk("t5_config_done", 32'(config_done), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
